pc_sequencer: RTL and testbench

Program-counter sequencer sitting directly upstream of the multi-cycle instruction controller. Holds the PC that addresses instruction memory, waits for the instruction-memory load to finish, then advances the PC once per completed instruction, applying BEQ/J targets when the controller raises its branch/jump enable. Counts retired instructions against the loaded program length and signals run completion.

---
 rtl/pc_sequencer_pkg.sv | 17 +
 rtl/pc_sequencer_target_calc.sv | 32 +++
 rtl/pc_sequencer.sv | 113 +++++++++++
 tb/tb_pc_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the program-counter sequencer: opcodes, FSM state encoding
// and the default sequential PC increment.
package pc_sequencer_pkg;

    localparam logic [5:0] OP_BEQ = 6'b100110;
    localparam logic [5:0] OP_J   = 6'b100100;

    localparam int PC_STEP_DEFAULT = 4;
    localparam int CNT_W           = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/pc_sequencer_target_calc.sv
// Next-PC arithmetic: sequential step, or a BEQ/J target formed from the
// sign-extended displacement shifted left by one. Purely combinational.
module pc_target_calc
    import pc_sequencer_pkg::*;
#(
    parameter int MemSize = 10,
    parameter int PC_STEP = PC_STEP_DEFAULT
) (
    input  logic [MemSize-1:0] pc,
    input  logic [5:0]         opcode,
    input  logic [13:0]        imm14,
    input  logic [23:0]        imm24,
    input  logic               beq_equal,
    input  logic               enable_bj,
    output logic [MemSize-1:0] pc_next
);

    logic [31:0] offset;

    always_comb begin
        offset = 32'(PC_STEP);
        if (enable_bj && opcode == OP_J) begin
            offset = {{7{imm24[23]}}, imm24, 1'b0};
        end else if (enable_bj && opcode == OP_BEQ && beq_equal) begin
            offset = {{17{imm14[13]}}, imm14, 1'b0};
        end
    end

    // Truncating the offset before the add gives the same wrap modulo 2^MemSize.
    assign pc_next = pc + MemSize'(offset);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: waits for instruction memory, advances the PC once
// per retired instruction (with BEQ/J targets) and halts after total_ir retires.
//
// state | meaning
// IDLE  | PC parked at PC_START, waiting for load_im_done
// RUN   | PC addresses a live instruction, advances on pc_step
// HALT  | program retired (or empty), PC frozen until reset
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int MemSize  = 10,
    parameter int PC_START = 0,
    parameter int PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_im_done,
    input  logic               pc_step,
    input  logic               enable_bj,
    input  logic [5:0]         opcode,
    input  logic [13:0]        imm14,
    input  logic [23:0]        imm24,
    input  logic               beq_equal,
    input  logic [CNT_W-1:0]   total_ir,
    output logic [MemSize-1:0] PC,
    output logic               pc_valid,
    output logic               run_done,
    output logic [CNT_W-1:0]   retired_cnt
);

    localparam logic [MemSize-1:0] PC_INIT = MemSize'(PC_START);

    state_t             state, state_nxt;
    logic [MemSize-1:0] pc_calc, pc_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               valid_nxt, done_nxt;
    logic               last_step;

    pc_target_calc #(
        .MemSize (MemSize),
        .PC_STEP (PC_STEP)
    ) u_target (
        .pc        (PC),
        .opcode    (opcode),
        .imm14     (imm14),
        .imm24     (imm24),
        .beq_equal (beq_equal),
        .enable_bj (enable_bj),
        .pc_next   (pc_calc)
    );

    // Compare in CNT_W+1 bits so a saturated count never aliases total_ir.
    assign last_step = ({1'b0, retired_cnt} + 17'd1) == {1'b0, total_ir};

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            PC          <= PC_INIT;
            retired_cnt <= '0;
            pc_valid    <= 1'b0;
            run_done    <= 1'b0;
        end else begin
            state       <= state_nxt;
            PC          <= pc_nxt;
            retired_cnt <= cnt_nxt;
            pc_valid    <= valid_nxt;
            run_done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (load_im_done) begin
                    state_nxt = (total_ir == '0) ? HALT : RUN;
                end
            end
            RUN: begin
                if (pc_step && last_step) begin
                    state_nxt = HALT;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; flags follow the next state so
    // run_done and pc_valid change together with the final PC update.
    always_comb begin
        pc_nxt  = PC;
        cnt_nxt = retired_cnt;
        case (state)
            IDLE: begin
                pc_nxt  = PC_INIT;
                cnt_nxt = '0;
            end
            RUN: begin
                if (pc_step) begin
                    pc_nxt = pc_calc;
                    if (retired_cnt != '1) begin
                        cnt_nxt = retired_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        valid_nxt = (state_nxt == RUN);
        done_nxt  = (state_nxt == HALT);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer: each record is driven on the falling edge,
// its expected outputs queued, and checked just after the following rising edge.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_im_done;
    logic        pc_step;
    logic        enable_bj;
    logic [5:0]  opcode;
    logic [13:0] imm14;
    logic [23:0] imm24;
    logic        beq_equal;
    logic [15:0] total_ir;
    logic [9:0]  PC;
    logic        pc_valid;
    logic        run_done;
    logic [15:0] retired_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pc_sequencer #(.MemSize(10), .PC_START(0), .PC_STEP(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .load_im_done (load_im_done),
        .pc_step      (pc_step),
        .enable_bj    (enable_bj),
        .opcode       (opcode),
        .imm14        (imm14),
        .imm24        (imm24),
        .beq_equal    (beq_equal),
        .total_ir     (total_ir),
        .PC           (PC),
        .pc_valid     (pc_valid),
        .run_done     (run_done),
        .retired_cnt  (retired_cnt)
    );

    typedef struct {
        logic        rst;
        logic        ld;
        logic [15:0] tir;
        logic        step;
        logic        en;
        logic [5:0]  op;
        logic [13:0] i14;
        logic [23:0] i24;
        logic        eq;
        logic [9:0]  pc;
        logic        valid;
        logic        done;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [9:0]  pc;
        logic        valid;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic rst, input logic ld, input logic [15:0] tir,
                                input logic step, input logic en, input logic [5:0] op,
                                input logic [13:0] i14, input logic [23:0] i24, input logic eq,
                                input logic [9:0] pc, input logic valid, input logic done,
                                input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.ld = ld; v.tir = tir; v.step = step; v.en = en; v.op = op;
        v.i14 = i14; v.i24 = i24; v.eq = eq;
        v.pc = pc; v.valid = valid; v.done = done; v.cnt = cnt;
        return v;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: no expected record queued");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (PC !== e.pc) begin
            errors++;
            $display("FAIL vec%0d PC: got %0d expected %0d", e.idx, PC, e.pc);
        end
        checks++;
        if (pc_valid !== e.valid) begin
            errors++;
            $display("FAIL vec%0d pc_valid: got %b expected %b", e.idx, pc_valid, e.valid);
        end
        checks++;
        if (run_done !== e.done) begin
            errors++;
            $display("FAIL vec%0d run_done: got %b expected %b", e.idx, run_done, e.done);
        end
        checks++;
        if (retired_cnt !== e.cnt) begin
            errors++;
            $display("FAIL vec%0d retired_cnt: got %0d expected %0d", e.idx, retired_cnt, e.cnt);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clock);
        reset        = v.rst;
        load_im_done = v.ld;
        total_ir     = v.tir;
        pc_step      = v.step;
        enable_bj    = v.en;
        opcode       = v.op;
        imm14        = v.i14;
        imm24        = v.i24;
        beq_equal    = v.eq;
        e.idx = idx; e.pc = v.pc; e.valid = v.valid; e.done = v.done; e.cnt = v.cnt;
        sb.push_back(e);
        @(posedge clock);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load_im_done = 1'b0; pc_step = 1'b0; enable_bj = 1'b0;
        opcode = 6'd0; imm14 = 14'd0; imm24 = 24'd0; beq_equal = 1'b0; total_ir = 16'd0;

        // Basic run of three sequential instructions, then HALT holds.
        tbl.push_back(mk(1, 0, 3, 0, 0, 0,      0, 0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3, 0, 0, 0,      0, 0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0,      0, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3, 1, 0, 0,      0, 0, 0,   4, 1, 0, 1));
        tbl.push_back(mk(0, 0, 3, 1, 0, 0,      0, 0, 0,   8, 1, 0, 2));
        tbl.push_back(mk(0, 0, 3, 1, 0, 0,      0, 0, 0,  12, 0, 1, 3));
        tbl.push_back(mk(0, 0, 3, 1, 1, OP_J,   0, 24'h000010, 0, 12, 0, 1, 3));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0,      0, 0, 0,  12, 0, 1, 3));

        // Long program exercising branch/jump targets and wrap-around.
        tbl.push_back(mk(1, 0, 100, 0, 0, 0,      0, 0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 100, 0, 0, 0,      0, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 100, 1, 0, 0,      0, 0, 0,   4, 1, 0, 1));
        tbl.push_back(mk(0, 1, 100, 1, 0, 0,      0, 0, 0,   8, 1, 0, 2));
        tbl.push_back(mk(0, 1, 100, 1, 1, OP_J,   0, 24'hFFFFFC, 0,   0, 1, 0, 3));
        tbl.push_back(mk(0, 1, 100, 1, 0, 0,      0, 0, 0,   4, 1, 0, 4));
        tbl.push_back(mk(0, 1, 100, 1, 1, OP_BEQ, 14'd6, 0, 1,  16, 1, 0, 5));
        tbl.push_back(mk(0, 1, 100, 0, 1, OP_J,   0, 24'h000040, 0,  16, 1, 0, 5));
        tbl.push_back(mk(0, 1, 100, 1, 1, OP_J,   0, 24'hFFFFFA, 0,   4, 1, 0, 6));
        tbl.push_back(mk(0, 1, 100, 1, 1, OP_BEQ, 14'd6, 0, 0,   8, 1, 0, 7));
        tbl.push_back(mk(0, 1, 100, 1, 1, 6'd0,   14'd6, 24'd100, 1, 12, 1, 0, 8));
        tbl.push_back(mk(0, 1, 100, 1, 0, OP_BEQ, 14'd6, 0, 1,  16, 1, 0, 9));
        tbl.push_back(mk(0, 0, 100, 1, 1, OP_J,   0, 24'd502, 0, 1020, 1, 0, 10));
        tbl.push_back(mk(0, 0, 100, 1, 0, 0,      0, 0, 0,   0, 1, 0, 11));
        tbl.push_back(mk(0, 0, 100, 1, 1, OP_J,   0, 24'hFFFFFE, 0, 1020, 1, 0, 12));
        tbl.push_back(mk(0, 0, 100, 1, 1, OP_BEQ, 14'h3FFE, 0, 1, 1016, 1, 0, 13));
        // Reset coincident with pc_step wins; load still high restarts the run.
        tbl.push_back(mk(1, 1, 100, 1, 1, OP_J,   0, 24'd8, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 100, 0, 0, 0,      0, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 100, 1, 0, 0,      0, 0, 0,   4, 1, 0, 1));

        // Final instruction is a taken BEQ: HALT with the branched PC.
        tbl.push_back(mk(1, 0, 2, 0, 0, 0,      0, 0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 0, 0,      0, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 2, 1, 0, 0,      0, 0, 0,   4, 1, 0, 1));
        tbl.push_back(mk(0, 1, 2, 1, 1, OP_BEQ, 14'd6, 0, 1,  16, 0, 1, 2));

        // Empty program goes straight to HALT.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,      0, 0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,      0, 0, 0,   0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,      0, 0, 0,   0, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_leftover: %0d records unchecked, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
